skew_bank_ctrl: RTL
===================

Name: skew_bank_ctrl

Overview:
- Initiator/controller for a pair of skewed tag banks: a left bank (SIDE=0) and a right bank (SIDE=1).
- Accepts lookup/insert requests over a valid/ready handshake.
- Drives both banks' read strobes and read address in parallel, then samples their combinational hit flags.
- Returns a hit/side response; on a miss with insert requested, writes the address into a victim bank chosen by a round-robin pointer.
- Sits between the prefetch/filter request source and the two bank instances.

Parameters:
- WIDTH, 64, address/data width presented to the banks.
- TAG_WIDTH, 12, tag width held by each bank (informational; passed through to bank instances at top level).
- INDEX_WIDTH, 6, bank index width (informational; passed through).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- req_addr_i  in  WIDTH  request address.
- req_insert_i  in  1  on miss, insert the address into a bank.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  consumer accepts the response.
- resp_hit_o  out  1  address hit in either bank.
- resp_side_o  out  1  side that hit, or side written on insert; 0 on plain miss.
- bank_read_o  out  1  read strobe, shared by both banks.
- bank_addr_o  out  WIDTH  read address, shared by both banks.
- bank0_write_o  out  1  write strobe, left bank.
- bank1_write_o  out  1  write strobe, right bank.
- bank_wdata_o  out  WIDTH  write data, shared by both banks.
- bank0_hit_i  in  1  left bank hit.
- bank1_hit_i  in  1  right bank hit.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, address/insert registers cleared.
  - All outputs 0, except req_ready_o=1 once in IDLE.
- State machine: IDLE -> LOOKUP -> [INSERT] -> RESP -> IDLE.
- req_ready_o = (state==IDLE). Request accepted on the edge where req_valid_i & req_ready_o; addr and insert flag are registered.
- LOOKUP (1 cycle):
  - bank_read_o=1, bank_addr_o=registered addr.
  - Bank hit flags sampled at the end of the cycle; hit = bank0_hit_i | bank1_hit_i.
  - If hit: side=0 when bank0_hit_i, else 1 (left wins when both hit).
  - If miss & insert -> INSERT; otherwise -> RESP.
- INSERT (1 cycle):
  - bank{rr_ptr}_write_o=1, bank_wdata_o=registered addr.
  - side=rr_ptr, then rr_ptr toggles. Next state RESP.
  - Exactly one write strobe high, for exactly one cycle.
- RESP:
  - resp_valid_o=1; resp_hit_o/resp_side_o held stable until resp_ready_i.
  - On resp_valid_o & resp_ready_i -> IDLE.
  - resp_hit_o=0 after an insert.
- Latency from the accept edge:
  - No insert: resp_valid_o in cycle 2.
  - Insert: resp_valid_o in cycle 3.
  - Throughput: at most one request per 3 (no insert) or 4 (insert) cycles.
- Outside LOOKUP, bank_read_o=0 and bank_addr_o holds its last value. Outside INSERT, both write strobes are 0.
- Reset mid-operation: any in-flight request is dropped with no response and no write. Write strobe drops immediately (asynchronous).
- rr_ptr advances only on an actual insert, never on hits or non-insert misses.

Optional Feature:
- Macro SKEW_BANK_STATS_EN.
- When defined:
  - Adds outputs stat_lookups_o, stat_hits_o, stat_inserts_o, each 32 bits.
  - stat_lookups_o increments on each LOOKUP exit; stat_hits_o on each hit; stat_inserts_o on each INSERT.
  - Counters saturate at all-ones and clear on reset.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package skew_bank_pkg:
  - typedef enum state_t {IDLE, LOOKUP, INSERT, RESP}.
  - localparam SIDE_LEFT=0, SIDE_RIGHT=1.
  - localparam STAT_WIDTH=32.
- Optional sub-module skew_bank_stats (three saturating counters), instantiated under SKEW_BANK_STATS_EN.

Test Plan:
1. After reset, lookup addr 0x1234, insert=0, both hits 0 -> bank_read_o pulses once with bank_addr_o=0x1234; resp_hit_o=0, resp_side_o=0 two cycles after accept; no write strobe.
2. Insert 0x1234 (miss), then insert 0x5678 (miss):
   - First: bank0_write_o one cycle with bank_wdata_o=0x1234, resp_side_o=0.
   - Second: bank1_write_o with bank_wdata_o=0x5678, resp_side_o=1.
3. Lookup with bank1_hit_i=1 and insert=1 -> resp_hit_o=1, resp_side_o=1, no write, rr_ptr unchanged. Both hits=1 -> resp_side_o=0.
4. Hold resp_ready_i=0 for 5 cycles in RESP -> resp_valid_o/hit/side stable and req_ready_o=0 throughout; IDLE the cycle after the ready handshake.
5. Assert rst=0 during the INSERT cycle -> bank0_write_o falls immediately, no resp_valid_o follows, req_ready_o=1 after release, rr_ptr=0.
6. With SKEW_BANK_STATS_EN: 3 lookups (1 hit, 2 insert-misses) -> stat_lookups_o=3, stat_hits_o=1, stat_inserts_o=2.

Source files
------------

// File: rtl/skew_bank_pkg.sv
// rtl/skew_bank_pkg.sv - shared types and constants for the skewed tag bank controller
package skew_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    INSERT = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  localparam int STAT_WIDTH = 32;

  // Left bank takes priority when both banks report a hit.
  function automatic logic hit_side(input logic left_hit, input logic right_hit);
    if (left_hit) begin
      return SIDE_LEFT;
    end
    return right_hit ? SIDE_RIGHT : SIDE_LEFT;
  endfunction

endpackage

// File: rtl/skew_bank_stats.sv
// rtl/skew_bank_stats.sv - saturating lookup/hit/insert event counters
module skew_bank_stats
  import skew_bank_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_inc_i,
  input  logic                  hit_inc_i,
  input  logic                  insert_inc_i,
  output logic [STAT_WIDTH-1:0] stat_lookups_o,
  output logic [STAT_WIDTH-1:0] stat_hits_o,
  output logic [STAT_WIDTH-1:0] stat_inserts_o
);

  logic [STAT_WIDTH-1:0] lookups_q, lookups_d;
  logic [STAT_WIDTH-1:0] hits_q, hits_d;
  logic [STAT_WIDTH-1:0] inserts_q, inserts_d;

  // Each counter sticks at all-ones instead of wrapping.
  always_comb begin
    lookups_d = lookups_q;
    hits_d    = hits_q;
    inserts_d = inserts_q;
    if (lookup_inc_i && (lookups_q != '1)) begin
      lookups_d = lookups_q + 1'b1;
    end
    if (hit_inc_i && (hits_q != '1)) begin
      hits_d = hits_q + 1'b1;
    end
    if (insert_inc_i && (inserts_q != '1)) begin
      inserts_d = inserts_q + 1'b1;
    end
  end

  // Counter state, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookups_q <= '0;
      hits_q    <= '0;
      inserts_q <= '0;
    end else begin
      lookups_q <= lookups_d;
      hits_q    <= hits_d;
      inserts_q <= inserts_d;
    end
  end

  assign stat_lookups_o = lookups_q;
  assign stat_hits_o    = hits_q;
  assign stat_inserts_o = inserts_q;

endmodule

// File: rtl/skew_bank_ctrl.sv
// rtl/skew_bank_ctrl.sv - lookup/insert controller for a left/right skewed tag bank pair (optional counters: SKEW_BANK_STATS_EN)
module skew_bank_ctrl
  import skew_bank_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int TAG_WIDTH   = 12,
  parameter int INDEX_WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic             req_insert_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_hit_o,
  output logic             resp_side_o,
  output logic             bank_read_o,
  output logic [WIDTH-1:0] bank_addr_o,
  output logic             bank0_write_o,
  output logic             bank1_write_o,
  output logic [WIDTH-1:0] bank_wdata_o,
  input  logic             bank0_hit_i,
  input  logic             bank1_hit_i
`ifdef SKEW_BANK_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_lookups_o,
  output logic [STAT_WIDTH-1:0] stat_hits_o,
  output logic [STAT_WIDTH-1:0] stat_inserts_o
`endif
);

  // The bank geometry only travels to the bank instances; reject shapes that cannot fit the address.
  if ((TAG_WIDTH > WIDTH) || (INDEX_WIDTH > WIDTH)) begin : g_geometry_check
    $error("skew_bank_ctrl: TAG_WIDTH/INDEX_WIDTH exceed WIDTH");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             insert_q, insert_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             hit_q, hit_d;
  logic             side_q, side_d;
  logic             any_hit;

  assign any_hit = bank0_hit_i | bank1_hit_i;

  // Next-state and response capture: one LOOKUP cycle, an optional INSERT cycle, then hold RESP until taken.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    insert_d = insert_q;
    rr_ptr_d = rr_ptr_q;
    hit_d    = hit_q;
    side_d   = side_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          insert_d = req_insert_i;
          hit_d    = 1'b0;
          side_d   = SIDE_LEFT;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d  = any_hit;
        side_d = hit_side(bank0_hit_i, bank1_hit_i);
        if (!any_hit && insert_q) begin
          state_d = INSERT;
        end else begin
          state_d = RESP;
        end
      end
      INSERT: begin
        // The victim side is reported, and the pointer only moves on a real write.
        hit_d    = 1'b0;
        side_d   = rr_ptr_q;
        rr_ptr_d = ~rr_ptr_q;
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state; reset drops any in-flight request without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      insert_q <= 1'b0;
      rr_ptr_q <= 1'b0;
      hit_q    <= 1'b0;
      side_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      insert_q <= insert_d;
      rr_ptr_q <= rr_ptr_d;
      hit_q    <= hit_d;
      side_q   <= side_d;
    end
  end

  // Strobes decode straight from state so the asynchronous reset removes them at once.
  // addr_q only changes on the accept edge, so the bank address holds its last value outside LOOKUP.
  assign req_ready_o   = (state_q == IDLE);
  assign bank_read_o   = (state_q == LOOKUP);
  assign bank_addr_o   = addr_q;
  assign bank0_write_o = (state_q == INSERT) && (rr_ptr_q == SIDE_LEFT);
  assign bank1_write_o = (state_q == INSERT) && (rr_ptr_q == SIDE_RIGHT);
  assign bank_wdata_o  = addr_q;
  assign resp_valid_o  = (state_q == RESP);
  assign resp_hit_o    = (state_q == RESP) && hit_q;
  assign resp_side_o   = (state_q == RESP) && side_q;

`ifdef SKEW_BANK_STATS_EN
  skew_bank_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .lookup_inc_i   (state_q == LOOKUP),
    .hit_inc_i      ((state_q == LOOKUP) && any_hit),
    .insert_inc_i   (state_q == INSERT),
    .stat_lookups_o (stat_lookups_o),
    .stat_hits_o    (stat_hits_o),
    .stat_inserts_o (stat_inserts_o)
  );
`endif

endmodule
